pc_unit: RTL

- Parametrised successor to the single-cycle program counter, used as the fetch-stage PC generator.
- Adds a programmable reset vector, pipeline stall, register-indirect jumps (JALR), a return-address stack (RAS) for call/return prediction, a halt/trap state machine and misaligned-target detection.
- Drives the instruction-memory address and a fetch-valid qualifier to the fetch stage.

---
 rtl/pc_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Fetch-stage PC generator: reset vector, stall, branch/JALR redirect, return-address stack, halt/trap FSM.
// Redirects appear on pc one cycle after sampling; stall holds everything, no bubbles are inserted.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             pcsrc,
  input  logic             jalr,
  input  logic [WIDTH-1:0] immop,
  input  logic [WIDTH-1:0] rs1,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             trap,
  output logic             ras_empty
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             trap_q, trap_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_tgt;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] redir_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             redir;
  logic             misal;
  logic             push;
  logic             pop;

  assign pc_plus4    = pc_q + WIDTH'(4);
  assign pc          = pc_q;
  assign fetch_valid = (state_q == S_RUN);
  assign trap        = trap_q;
  assign ras_empty   = (cnt_q == '0);

  assign jalr_sum  = rs1 + immop;
  assign jalr_tgt  = {jalr_sum[WIDTH-1:1], 1'b0};
  assign br_tgt    = pc_q + immop;
  assign redir     = jalr | pcsrc;
  assign redir_tgt = jalr ? jalr_tgt : br_tgt;
  assign misal     = (redir_tgt[1:0] != 2'b00);
  // sp_q points at the next free slot, so the top lives one below it
  assign ras_top   = ras_q[sp_q - PTR_W'(1)];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = trap_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (!stall) state_d = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = S_HALT;
          end else if (redir) begin
            // A misaligned target never reaches pc; the core halts with the trap raised.
            if (misal) begin
              trap_d  = 1'b1;
              state_d = S_HALT;
            end else begin
              pc_d = redir_tgt;
              push = call;
            end
          end else if (ret && !ras_empty) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d  = sp_q + PTR_W'(1);
      cnt_d = (cnt_q == RAS_FULL) ? cnt_q : cnt_q + (PTR_W+1)'(1);
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      trap_q  <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entries are only read while counted valid, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) ras_q[sp_q] <= pc_plus4;
  end

endmodule
